// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int PC_INC     = 4;
  // Buffer entries carry a full 32-bit PC; narrower ADDR_W builds zero-extend into it.
  localparam int ENTRY_PC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of fetch_entry_t words with push/pop/clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  fetch_entry_t     mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage needs no reset: the head is only consumed while count_o is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction prefetcher feeding decode
// Optional FETCH_STATS_EN adds fetch_count/flush_count outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] target_aligned;
  logic [CNT_W-1:0]  buf_count, count_after;
  fetch_entry_t      head, push_entry;
  logic              push, pop;

  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};

  // A redirect suppresses both sides of the buffer in the same cycle.
  assign push        = (state_q == WAIT) && imem_rvalid && !pc_src;
  assign pop         = instr_valid && dec_ready && !pc_src;
  assign count_after = buf_count + CNT_W'(push) - CNT_W'(pop);

  assign push_entry.pc    = ENTRY_PC_W'(req_pc_q);
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (pc_src),
    .head_o      (head),
    .count_o     (buf_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(PC_INC);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) state_d = (count_after < CNT_W'(BUF_DEPTH)) ? REQ : HOLD;
      end
      HOLD: begin
        if (buf_count < CNT_W'(BUF_DEPTH)) state_d = REQ;
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Any request already granted must have its response swallowed in DROP.
    if (pc_src) begin
      pc_d = target_aligned;
      case (state_q)
        REQ:     state_d = imem_gnt ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (buf_count != '0);
  assign instruction = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc[ADDR_W-1:0] : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_q + 32'(pop);
      flush_count_q <= flush_count_q + 16'(pc_src);
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
